// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial add datapath (transmit and receive sides).
package serial_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Bits needed to count 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Modulo-WIDTH bit counter with clear, load-to-one and increment; term flags the WIDTH-th accepted bit.
// Latency: count updates one clock after the control; term is same-cycle. No backpressure.
module serial_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic r,
    input  logic clr,
    input  logic load1,
    input  logic inc,
    output logic term
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count;

    assign term = inc && (count == LAST);

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load1) begin
            count <= CNT_W'(1);
        end else if (inc) begin
            count <= term ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_sum_deser.sv
// Deserialises the LSB-first sum stream plus final carry into a WIDTH-bit word on valid/ready.
// Latency 1 clock from last bit to out_valid; while a result is pending, incoming bits are dropped and flagged.
module serial_sum_deser
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             bit_valid,
    input  logic             first,
    input  logic             s_in,
    input  logic             c_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             busy,
    output logic             overrun,
    output logic             sync_err
);

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] sh_start;
    logic             start_bit;
    logic             handshake;
    logic             cnt_load1;
    logic             cnt_inc;
    logic             last_bit;

    assign sh_next   = {s_in, sh[WIDTH-1:1]};
    assign sh_start  = {s_in, {(WIDTH-1){1'b0}}};
    assign start_bit = bit_valid && first;
    assign handshake = (state == HOLD) && out_ready;

    // A frame start is honoured from IDLE, mid-frame (resync) and in the handshake cycle.
    assign cnt_load1 = start_bit && ((state == IDLE) || (state == SHIFT) || handshake);
    assign cnt_inc   = bit_valid && !first && (state == SHIFT);

    serial_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .r     (r),
        .clr   (1'b0),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .term  (last_bit)
    );

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state     <= IDLE;
            sh        <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_bit) begin
                        sh    <= sh_start;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        if (first) begin
                            sh       <= sh_start;
                            sync_err <= 1'b1;
                        end else begin
                            sh <= sh_next;
                            if (last_bit) begin
                                sum_out   <= sh_next;
                                carry_out <= c_in;
                                out_valid <= 1'b1;
                                state     <= HOLD;
                                busy      <= 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start_bit) begin
                            sh    <= sh_start;
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bit_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sum_deser.sv
// Directed bench for serial_sum_deser with a frame-level reference model checked every cycle.
module tb_serial_sum_deser;

    localparam int W = 8;

    logic         clk;
    logic         r;
    logic         bit_valid;
    logic         first;
    logic         s_in;
    logic         c_in;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] sum_out;
    logic         carry_out;
    logic         busy;
    logic         overrun;
    logic         sync_err;

    int n_chk  = 0;
    int n_fail = 0;

    serial_sum_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .r         (r),
        .bit_valid (bit_valid),
        .first     (first),
        .s_in      (s_in),
        .c_in      (c_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .busy      (busy),
        .overrun   (overrun),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame bits collected in a queue, result formed arithmetically.
    bit           q[$];
    bit           in_frame;
    bit           pending;
    logic [W-1:0] m_sum;
    logic         m_carry;
    logic         m_ovr;
    logic         m_sync;

    always @(posedge clk or negedge r) begin
        if (!r) begin
            q.delete();
            in_frame = 0;
            pending  = 0;
            m_sum    = '0;
            m_carry  = 1'b0;
            m_ovr    = 1'b0;
            m_sync   = 1'b0;
        end else begin
            m_sync = 1'b0;
            if (pending) begin
                if (out_ready) begin
                    pending = 0;
                    if (bit_valid && first) begin
                        q.delete();
                        q.push_back(s_in);
                        in_frame = 1;
                    end
                end else if (bit_valid) begin
                    m_ovr = 1'b1;
                end
            end else if (in_frame) begin
                if (bit_valid) begin
                    if (first) begin
                        q.delete();
                        m_sync = 1'b1;
                    end
                    q.push_back(s_in);
                    if (q.size() == W) begin
                        logic [31:0] v;
                        v = 0;
                        for (int i = 0; i < W; i++) v = v + (32'(q[i]) << i);
                        m_sum    = v[W-1:0];
                        m_carry  = c_in;
                        pending  = 1;
                        in_frame = 0;
                        q.delete();
                    end
                end
            end else if (bit_valid && first) begin
                q.delete();
                q.push_back(s_in);
                in_frame = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_out_valid", 32'(out_valid), 32'(pending));
        chk("cyc_sum_out",   32'(sum_out),   32'(m_sum));
        chk("cyc_carry_out", 32'(carry_out), 32'(m_carry));
        chk("cyc_busy",      32'(busy),      32'(in_frame));
        chk("cyc_overrun",   32'(overrun),   32'(m_ovr));
        chk("cyc_sync_err",  32'(sync_err),  32'(m_sync));
    end

    task automatic cyc(input logic bv, input logic f, input logic s, input logic c, input logic rdy);
        bit_valid = bv;
        first     = f;
        s_in      = s;
        c_in      = c;
        out_ready = rdy;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] val, input logic carry, input logic rdy);
        for (int k = 0; k < W; k++)
            cyc(1'b1, k == 0, val[k], (k == W - 1) ? carry : 1'b0, rdy);
    endtask

    initial begin
        logic [W-1:0] v;
        r = 1'b0;
        bit_valid = 1'b0; first = 1'b0; s_in = 1'b0; c_in = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_sum_out",   32'(sum_out),   0);
        chk("reset_busy",      32'(busy),      0);
        chk("reset_overrun",   32'(overrun),   0);
        r = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);   // bit without first in IDLE is ignored
        chk("idle_ignore_busy", 32'(busy), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 0x96, accepted immediately
        send_frame(8'h96, 1'b0, 1'b1);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_sum",   32'(sum_out),   32'h96);
        chk("t1_model", 32'(m_sum),     32'h96);
        chk("t1_carry", 32'(carry_out), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_done_valid", 32'(out_valid), 0);
        chk("t1_done_busy",  32'(busy),      0);

        // 0xFF + 0x01
        send_frame(8'h00, 1'b1, 1'b1);
        chk("t2_sum",   32'(sum_out),   32'h00);
        chk("t2_carry", 32'(carry_out), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // overrun while result pending
        send_frame(8'h96, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_sum",     32'(sum_out),   32'h96);
        chk("t3_valid",   32'(out_valid), 1);
        chk("t3_overrun", 32'(overrun),   1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_after_hs_valid",   32'(out_valid), 0);
        chk("t3_after_hs_overrun", 32'(overrun),   1);

        // resync mid-frame
        for (int k = 0; k < 4; k++) cyc(1'b1, k == 0, 1'b1, 1'b0, 1'b1);
        v = 8'hA5;
        cyc(1'b1, 1'b1, v[0], 1'b0, 1'b1);
        chk("t4_sync_err", 32'(sync_err), 1);
        chk("t4_busy",     32'(busy),     1);
        for (int k = 1; k < W; k++) cyc(1'b1, 1'b0, v[k], (k == W - 1), 1'b1);
        chk("t4_sync_clear", 32'(sync_err),  0);
        chk("t4_sum",        32'(sum_out),   32'hA5);
        chk("t4_carry",      32'(carry_out), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-frame
        v = 8'hFF;
        for (int k = 0; k < 5; k++) cyc(1'b1, k == 0, v[k], 1'b0, 1'b1);
        bit_valid = 1'b0; first = 1'b0;
        #2 r = 1'b0;
        #1;
        chk("t5_rst_busy",    32'(busy),      0);
        chk("t5_rst_valid",   32'(out_valid), 0);
        chk("t5_rst_sum",     32'(sum_out),   0);
        chk("t5_rst_overrun", 32'(overrun),   0);
        @(negedge clk);
        r = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("t5_sum",   32'(sum_out),   32'h3C);
        chk("t5_valid", 32'(out_valid), 1);

        // back-to-back frames, handshake coincides with first
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("t6a_sum", 32'(sum_out), 32'h5A);
        v = 8'hC3;
        for (int k = 0; k < W; k++) begin
            cyc(1'b1, k == 0, v[k], 1'b0, 1'b1);
            if (k == 0) chk("t6_no_bubble_busy", 32'(busy), 1);
            if (k == W - 2) chk("t6_not_early", 32'(out_valid), 0);
        end
        chk("t6b_valid", 32'(out_valid), 1);
        chk("t6b_sum",   32'(sum_out),   32'hC3);
        chk("t6b_carry", 32'(carry_out), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_end_valid", 32'(out_valid), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
